// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage and the M-extension sequencer.
// The pipeline side is the master. The sequencer is the slave.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      md_op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_data;

  modport master (
    output start, md_op, rs1_data, rs2_data, flush,
    input  busy, done, md_data
  );

  modport slave (
    input  start, md_op, rs1_data, rs2_data, flush,
    output busy, done, md_data
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Multiplication uses a 32-step shift-add. Division uses a 32-step restoring algorithm.
// Both run on the same {hi,lo} register pair. Sign handling is done on magnitudes:
// the unit negates the operands at start and fixes the sign of the result in one final cycle.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Two's-complement negation helpers for single and double width values.
  function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
    return -v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
    return -v;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             neg_res;
  logic [XLEN-1:0]  opnd;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi;        // product high half / partial remainder
  logic [XLEN-1:0]  lo;        // multiplier being consumed / quotient being built
  logic [XLEN-1:0]  md_data;

  logic             accept;
  logic             op_is_div;

  // Start-time decode: signedness, operand magnitudes, result sign, special cases.
  logic             a_signed;
  logic             b_signed;
  logic             neg_start;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic             div_zero;
  logic             div_ovf;
  logic             special;
  logic [XLEN-1:0]  special_res;

  // Classify the incoming op and build the magnitudes it will iterate on.
  always_comb begin
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    neg_start   = 1'b0;
    special_res = '0;
    case (bus.md_op)
      OP_MULH: begin
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        neg_start = bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1];
      end
      OP_MULHSU: begin
        a_signed  = 1'b1;
        neg_start = bus.rs1_data[XLEN-1];
      end
      OP_DIV: begin
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        neg_start = bus.rs1_data[XLEN-1] ^ bus.rs2_data[XLEN-1];
      end
      OP_REM: begin
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        neg_start = bus.rs1_data[XLEN-1];
      end
      default: begin
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        neg_start = 1'b0;
      end
    endcase

    a_mag = (a_signed && bus.rs1_data[XLEN-1]) ? neg_w(bus.rs1_data) : bus.rs1_data;
    b_mag = (b_signed && bus.rs2_data[XLEN-1]) ? neg_w(bus.rs2_data) : bus.rs2_data;

    div_zero = bus.md_op[2] && (bus.rs2_data == '0);
    div_ovf  = ((bus.md_op == OP_DIV) || (bus.md_op == OP_REM)) &&
               (bus.rs1_data == INT_MIN) && (bus.rs2_data == ALL_ONES);
    special  = div_zero || div_ovf;

    // Divide by zero: quotient all ones, remainder is the dividend.
    // Overflow: quotient is INT_MIN, remainder is zero.
    if (div_zero) begin
      special_res = bus.md_op[1] ? bus.rs1_data : ALL_ONES;
    end else if (div_ovf) begin
      special_res = bus.md_op[1] ? '0 : INT_MIN;
    end
  end

  assign accept    = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign op_is_div = op[2];

  // One iteration of either algorithm.
  logic [XLEN:0]            mul_sum;
  logic [XLEN:0]            rem_sh;
  logic signed [XLEN+1:0]   trial;
  logic                     trial_ok;

  // Datapath for a single iteration step.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {hi, lo[XLEN-1]};
    trial    = $signed({1'b0, rem_sh}) - $signed({2'b00, opnd});
    trial_ok = ~trial[XLEN+1];
  end

  // Final sign correction and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   fix_res;

  // Negate the product or quotient/remainder when the true result is negative, then pick the half.
  always_comb begin
    prod_fix = neg_res ? neg_dw({hi, lo}) : {hi, lo};
    div_sel  = op[1] ? hi : lo;
    div_fix  = neg_res ? neg_w(div_sel) : div_sel;
    case (op)
      OP_MUL:    fix_res = prod_fix[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV,
      OP_DIVU,
      OP_REM,
      OP_REMU:   fix_res = div_fix;
      default:   fix_res = div_fix;
    endcase
  end

  // Sequencer FSM and iteration counter. Flush wins over everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state <= special ? S_DONE : S_CALC;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= S_FIX;
          end
        end
        S_FIX:   state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture, iteration registers and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op      <= '0;
      neg_res <= 1'b0;
      opnd    <= '0;
      hi      <= '0;
      lo      <= '0;
      md_data <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        op      <= bus.md_op;
        neg_res <= neg_start;
        hi      <= '0;
        // Divide: lo starts as the dividend, opnd holds the divisor.
        // Multiply: lo starts as the multiplier, opnd holds the multiplicand.
        lo      <= bus.md_op[2] ? a_mag : b_mag;
        opnd    <= bus.md_op[2] ? b_mag : a_mag;
        if (special) begin
          md_data <= special_res;
        end
      end else if (state == S_CALC) begin
        if (op_is_div) begin
          hi <= trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], trial_ok};
        end else begin
          hi <= mul_sum[XLEN:1];
          lo <= {mul_sum[0], lo[XLEN-1:1]};
        end
      end else if (state == S_FIX) begin
        md_data <= fix_res;
      end
    end
  end

  assign bus.busy    = (state == S_CALC) || (state == S_FIX);
  assign bus.done    = (state == S_DONE);
  assign bus.md_data = md_data;

endmodule
